// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: index width, x0 and grant encodings.
package regfile_wb_arbiter_pkg;

    localparam int RegBus    = 32;
    localparam int RegNum    = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic {
        GRANT_EXU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared on the register-file write edge,
// plus the RAW/WAW hazard compare for the instruction presented for issue.
module regfile_wb_arbiter_wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 clr_en_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    input  logic                 iss_valid_i,
    input  logic [REG_IDX_W-1:0] iss_rs1_i,
    input  logic [REG_IDX_W-1:0] iss_rs2_i,
    input  logic [REG_IDX_W-1:0] iss_rd_i,
    output logic                 hazard_o,
    output logic [NREG-1:0]      pending_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Set is applied after clear so a same-cycle set/clear on one index leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
        if (set_en_i) pending_d[set_idx_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    // Bit 0 is never set, so x0 sources/destination can never raise a hazard.
    assign hazard_o  = iss_valid_i &
                       (pending_q[iss_rs1_i] | pending_q[iss_rs2_i] | pending_q[iss_rd_i]);
    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin EXU/LSU writeback arbiter owning the register-file write port,
// with a registered write stage and a pending scoreboard for issue stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exu_valid,
    output logic                 exu_ready,
    input  logic [REG_IDX_W-1:0] exu_rd,
    input  logic [XLEN-1:0]      exu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rs1,
    input  logic [REG_IDX_W-1:0] iss_rs2,
    input  logic [REG_IDX_W-1:0] iss_rd,
    input  logic                 iss_fire,
    output logic                 hazard,
    output logic                 rf_wen,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [NREG-1:0]      pending,
    output logic                 err_orphan
);

    // Handshake: a writeback transfers in any cycle where valid & ready. Ready is a pure
    // grant derived from both valids and last_grant; a requester holds rd/data while stalled.

    grant_e               last_grant_q, last_grant_d;
    logic                 rf_wen_q, rf_wen_d;
    logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 err_orphan_q, err_orphan_d;

    logic                 exu_gnt, lsu_gnt, any_gnt;
    logic [REG_IDX_W-1:0] gnt_rd;
    logic [XLEN-1:0]      gnt_data;
    logic [NREG-1:0]      pending_vec;

    // On a tie the source that did not win last time is granted.
    always_comb begin
        exu_gnt  = !rst && exu_valid && (!lsu_valid || last_grant_q == GRANT_LSU);
        lsu_gnt  = !rst && lsu_valid && (!exu_valid || last_grant_q == GRANT_EXU);
        any_gnt  = exu_gnt || lsu_gnt;
        gnt_rd   = lsu_gnt ? lsu_rd   : exu_rd;
        gnt_data = lsu_gnt ? lsu_data : exu_data;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wdata_d   = rf_wdata_q;
        err_orphan_d = err_orphan_q;
        if (any_gnt) begin
            last_grant_d = lsu_gnt ? GRANT_LSU : GRANT_EXU;
            if (gnt_rd != REG_X0) begin
                rf_wen_d   = 1'b1;
                rf_rd_d    = gnt_rd;
                rf_wdata_d = gnt_data;
                if (!pending_vec[gnt_rd]) err_orphan_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_EXU;
            rf_wen_q     <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Pending clears on the same edge the register file captures the write.
    regfile_wb_arbiter_wb_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (iss_fire && iss_rd != REG_X0),
        .set_idx_i  (iss_rd),
        .clr_en_i   (rf_wen_q),
        .clr_idx_i  (rf_rd_q),
        .iss_valid_i(iss_valid),
        .iss_rs1_i  (iss_rs1),
        .iss_rs2_i  (iss_rs2),
        .iss_rd_i   (iss_rd),
        .hazard_o   (hazard),
        .pending_o  (pending_vec)
    );

    assign exu_ready  = exu_gnt;
    assign lsu_ready  = lsu_gnt;
    assign rf_wen     = rf_wen_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wdata   = rf_wdata_q;
    assign pending    = pending_vec;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin ties, scoreboard hazards,
// x0 writebacks, orphan detection and reset during an in-flight write.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [4:0]      exu_rd, lsu_rd;
    logic [XLEN-1:0] exu_data, lsu_data;
    logic            iss_valid, iss_fire, hazard;
    logic [4:0]      iss_rs1, iss_rs2, iss_rd;
    logic            rf_wen, err_orphan;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pending;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_fire(iss_fire), .hazard(hazard),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .pending(pending), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_fire = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        next_cycle();
        idle();
        iss_valid = 1'b1; iss_rd = rd; iss_fire = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        next_cycle();
        exu_valid = 1'b1; exu_rd = 5'd1; lsu_valid = 1'b1; lsu_rd = 5'd2;
        @(negedge clk);
        n_vec++; if ({exu_ready, lsu_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {exu_ready, lsu_ready}); end
        n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen); end
        n_vec++; if (rf_rd !== 5'd0) begin n_err++; $display("FAIL reset_rf_rd: got %0d want 0", rf_rd); end
        n_vec++; if (rf_wdata !== 32'h0) begin n_err++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pending); end
        n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_err_orphan: got %b want 0", err_orphan); end
        next_cycle();
        idle();
        rst = 1'b0;
    endtask

    task automatic test_exu_single();
        issue(5'd5);
        @(negedge clk);
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL single_issue_hazard: got %b want 0", hazard); end
        next_cycle();
        idle();
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        @(negedge clk);
        n_vec++; if (pending[5] !== 1'b1) begin n_err++; $display("FAIL single_pending_set: got %b want 1", pending[5]); end
        n_vec++; if ({exu_ready, lsu_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b want 10", {exu_ready, lsu_ready}); end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if ({rf_wen, rf_rd} !== {1'b1, 5'd5}) begin n_err++; $display("FAIL single_write: got wen=%b rd=%0d want wen=1 rd=5", rf_wen, rf_rd); end
        n_vec++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); end
        n_vec++; if (pending[5] !== 1'b1) begin n_err++; $display("FAIL single_pending_hold: got %b want 1", pending[5]); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL single_pending_clear: got %h want 0", pending); end
        n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL single_wen_drop: got %b want 0", rf_wen); end
        n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL single_orphan: got %b want 0", err_orphan); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]      prev_rd;
        logic [XLEN-1:0] prev_data;
        int              e_n, l_n;
        logic            exp_l;
        e_n = 0; l_n = 0; prev_rd = '0; prev_data = '0;
        do_reset();
        issue(5'd3);
        issue(5'd4);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle();
            exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h3300_0000 + 32'(e_n);
            lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4400_0000 + 32'(l_n);
            @(negedge clk);
            exp_l = (i % 2 == 0);
            n_vec++; if ({exu_ready, lsu_ready} !== {!exp_l, exp_l}) begin n_err++; $display("FAIL tie_grant_%0d: got e=%b l=%b want e=%b l=%b", i, exu_ready, lsu_ready, !exp_l, exp_l); end
            if (i > 0) begin
                n_vec++; if ({rf_wen, rf_rd, rf_wdata} !== {1'b1, prev_rd, prev_data}) begin n_err++; $display("FAIL tie_write_%0d: got wen=%b rd=%0d data=%h want wen=1 rd=%0d data=%h", i, rf_wen, rf_rd, rf_wdata, prev_rd, prev_data); end
            end
            if (exp_l) begin prev_rd = 5'd4; prev_data = lsu_data; l_n++; end
            else       begin prev_rd = 5'd3; prev_data = exu_data; e_n++; end
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if ({rf_wen, rf_rd, rf_wdata} !== {1'b1, prev_rd, prev_data}) begin n_err++; $display("FAIL tie_write_last: got wen=%b rd=%0d data=%h want wen=1 rd=%0d data=%h", rf_wen, rf_rd, rf_wdata, prev_rd, prev_data); end
    endtask

    task automatic test_hazard();
        do_reset();
        issue(5'd7);
        @(negedge clk);
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_issue: got %b want 0", hazard); end
        next_cycle();
        idle();
        iss_valid = 1'b1; iss_rs1 = 5'd7;
        @(negedge clk);
        n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_raw_rs1: got %b want 1", hazard); end
        iss_rs1 = 5'd0; iss_rs2 = 5'd7; #1;
        n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_raw_rs2: got %b want 1", hazard); end
        iss_rs2 = 5'd0; iss_rd = 5'd7; #1;
        n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_waw: got %b want 1", hazard); end
        iss_rd = 5'd6; iss_rs1 = 5'd8; #1;
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_unrelated: got %b want 0", hazard); end
        iss_rd = 5'd0; iss_rs1 = 5'd7; iss_valid = 1'b0; #1;
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_no_valid: got %b want 0", hazard); end
        iss_valid = 1'b1;
        next_cycle();
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h0000_0777;
        @(negedge clk);
        n_vec++; if ({exu_ready, hazard} !== 2'b11) begin n_err++; $display("FAIL haz_grant_cycle: got ready=%b hazard=%b want 11", exu_ready, hazard); end
        next_cycle();
        exu_valid = 1'b0;
        @(negedge clk);
        n_vec++; if ({rf_wen, hazard} !== 2'b11) begin n_err++; $display("FAIL haz_write_cycle: got wen=%b hazard=%b want 11", rf_wen, hazard); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_release: got %b want 0", hazard); end
    endtask

    task automatic test_rd0();
        next_cycle();
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1;
        iss_valid = 1'b1;
        @(negedge clk);
        n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL rd0_ready: got %b want 1", lsu_ready); end
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL rd0_hazard_x0: got %b want 0", hazard); end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL rd0_wen: got %b want 0", rf_wen); end
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL rd0_pending: got %h want 0", pending); end
        n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL rd0_orphan: got %b want 0", err_orphan); end
    endtask

    task automatic test_orphan();
        next_cycle();
        idle();
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_0099;
        @(negedge clk);
        n_vec++; if (exu_ready !== 1'b1) begin n_err++; $display("FAIL orphan_ready: got %b want 1", exu_ready); end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if ({rf_wen, rf_rd, rf_wdata} !== {1'b1, 5'd9, 32'h0000_0099}) begin n_err++; $display("FAIL orphan_write: got wen=%b rd=%0d data=%h want wen=1 rd=9 data=00000099", rf_wen, rf_rd, rf_wdata); end
        n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
        do_reset();
        @(negedge clk);
        n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orphan_reset: got %b want 0", err_orphan); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        issue(5'd12);
        next_cycle();
        idle();
        exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 32'h0000_0C0C;
        @(negedge clk);
        n_vec++; if (exu_ready !== 1'b1) begin n_err++; $display("FAIL rmw_grant: got %b want 1", exu_ready); end
        next_cycle();
        rst = 1'b1;
        exu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
        @(negedge clk);
        n_vec++; if ({rf_wen, rf_rd} !== {1'b1, 5'd12}) begin n_err++; $display("FAIL rmw_inflight: got wen=%b rd=%0d want wen=1 rd=12", rf_wen, rf_rd); end
        n_vec++; if ({exu_ready, lsu_ready} !== 2'b00) begin n_err++; $display("FAIL rmw_ready_in_rst: got %b want 00", {exu_ready, lsu_ready}); end
        next_cycle();
        rst = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h66;
        @(negedge clk);
        n_vec++; if ({rf_wen, rf_rd, rf_wdata} !== {1'b0, 5'd0, 32'h0}) begin n_err++; $display("FAIL rmw_rf_after: got wen=%b rd=%0d data=%h want 0 0 0", rf_wen, rf_rd, rf_wdata); end
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL rmw_pending: got %h want 0", pending); end
        n_vec++; if ({exu_ready, lsu_ready} !== 2'b01) begin n_err++; $display("FAIL rmw_last_grant: got e=%b l=%b want e=0 l=1", exu_ready, lsu_ready); end
        next_cycle();
        lsu_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (exu_ready !== 1'b1) begin n_err++; $display("FAIL rmw_exu_next: got %b want 1", exu_ready); end
        next_cycle();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_exu_single();
        test_back_to_back();
        test_hazard();
        test_rd0();
        test_orphan();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
